// File: rtl/hwag_cfg_sequencer_if.sv
// Register bus between the hwag config sequencer (master) and the register file (slave).
`timescale 1ns/1ps
interface hwag_cfg_sequencer_if #(
  parameter int AW = 8,
  parameter int DW = 16
) ();
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [DW-1:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface

// File: rtl/hwag_cfg_sequencer.sv
// hwag configuration bus owner: replays the boot table after reset, then serves single host accesses.
// Optional HWAG_CFG_VERIFY_EN: read back every boot write and flag mismatches on boot_err.
`timescale 1ns/1ps
module hwag_cfg_sequencer #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int BOOT_LEN = 12,
  parameter int IDX_W    = 4,
  parameter int RD_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [DW-1:0]    tbl_data,
  input  logic             boot_start,
  output logic             boot_busy,
  output logic             boot_done,
  output logic             boot_err,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic [DW-1:0]    host_rdata,
  hwag_cfg_sequencer_if.master bus
);

  localparam int                CNT_W    = $clog2(RD_LAT + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BOOT_LEN - 1);
  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RD_LAT);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_HWR,
`ifdef HWAG_CFG_VERIFY_EN
    ST_VRD_WAIT,
`endif
    ST_HRD_WAIT
  } state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  tbl_idx_reg;
  logic [AW-1:0]     reg_addr_reg;
  logic [DW-1:0]     reg_wdata_reg;
  logic              reg_we_reg;
  logic              reg_re_reg;
  logic              host_ack_reg;
  logic [DW-1:0]     host_rdata_reg;
  logic              boot_done_reg;
  logic              start_pend_reg;
  logic [CNT_W-1:0]  lat_cnt_reg;
`ifdef HWAG_CFG_VERIFY_EN
  localparam logic [CNT_W-1:0] LAT_CMP = CNT_W'(RD_LAT + 1);
  logic              boot_err_reg;
  logic              vrd_last_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_BOOT;
      tbl_idx_reg    <= '0;
      reg_addr_reg   <= '0;
      reg_wdata_reg  <= '0;
      reg_we_reg     <= 1'b0;
      reg_re_reg     <= 1'b0;
      host_ack_reg   <= 1'b0;
      host_rdata_reg <= '0;
      boot_done_reg  <= 1'b0;
      start_pend_reg <= 1'b0;
      lat_cnt_reg    <= '0;
`ifdef HWAG_CFG_VERIFY_EN
      boot_err_reg   <= 1'b0;
      vrd_last_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_BOOT: begin
          reg_re_reg <= 1'b0;
          if (boot_start) begin
            // restart from entry 0 on the following cycle
            tbl_idx_reg    <= '0;
            reg_we_reg     <= 1'b0;
            start_pend_reg <= 1'b0;
`ifdef HWAG_CFG_VERIFY_EN
            boot_err_reg   <= 1'b0;
`endif
          end else begin
            reg_addr_reg  <= tbl_addr;
            reg_wdata_reg <= tbl_data;
            reg_we_reg    <= 1'b1;
`ifdef HWAG_CFG_VERIFY_EN
            lat_cnt_reg   <= '0;
            state_reg     <= ST_VRD_WAIT;
`else
            if (tbl_idx_reg == LAST_IDX) begin
              boot_done_reg <= 1'b1;
              tbl_idx_reg   <= '0;
              state_reg     <= ST_IDLE;
            end else begin
              tbl_idx_reg <= tbl_idx_reg + 1'b1;
            end
`endif
          end
        end

        ST_IDLE: begin
          reg_we_reg <= 1'b0;
          reg_re_reg <= 1'b0;
          if (start_pend_reg || boot_start) begin
            start_pend_reg <= 1'b0;
            boot_done_reg  <= 1'b0;
            tbl_idx_reg    <= '0;
            state_reg      <= ST_BOOT;
`ifdef HWAG_CFG_VERIFY_EN
            boot_err_reg   <= 1'b0;
`endif
          end else if (host_req) begin
            reg_addr_reg <= host_addr;
            if (host_we) begin
              reg_wdata_reg <= host_wdata;
              reg_we_reg    <= 1'b1;
              host_ack_reg  <= 1'b1;
              state_reg     <= ST_HWR;
            end else begin
              reg_re_reg  <= 1'b1;
              lat_cnt_reg <= '0;
              state_reg   <= ST_HRD_WAIT;
            end
          end
        end

        // one turnaround cycle so the host can drop or renew its request
        ST_HWR: begin
          reg_we_reg   <= 1'b0;
          host_ack_reg <= 1'b0;
          state_reg    <= ST_IDLE;
          if (boot_start) start_pend_reg <= 1'b1;
        end

        ST_HRD_WAIT: begin
          reg_re_reg <= 1'b0;
          if (boot_start) start_pend_reg <= 1'b1;
          if (lat_cnt_reg == LAT_LAST) begin
            host_rdata_reg <= bus.reg_rdata;
            host_ack_reg   <= 1'b1;
            state_reg      <= ST_HWR;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
          end
        end

`ifdef HWAG_CFG_VERIFY_EN
        // reg_wdata still holds this entry's table value while it is read back,
        // which lets the next entry's write overlap the compare cycle
        ST_VRD_WAIT: begin
          if (boot_start) begin
            tbl_idx_reg    <= '0;
            reg_we_reg     <= 1'b0;
            reg_re_reg     <= 1'b0;
            start_pend_reg <= 1'b0;
            boot_err_reg   <= 1'b0;
            state_reg      <= ST_BOOT;
          end else if (lat_cnt_reg == '0) begin
            reg_we_reg   <= 1'b0;
            reg_re_reg   <= 1'b1;
            vrd_last_reg <= (tbl_idx_reg == LAST_IDX);
            if (tbl_idx_reg != LAST_IDX) tbl_idx_reg <= tbl_idx_reg + 1'b1;
            lat_cnt_reg  <= CNT_W'(1);
          end else if (lat_cnt_reg != LAT_CMP) begin
            reg_re_reg  <= 1'b0;
            lat_cnt_reg <= lat_cnt_reg + CNT_W'(1);
          end else begin
            reg_re_reg <= 1'b0;
            if (bus.reg_rdata != reg_wdata_reg) boot_err_reg <= 1'b1;
            if (vrd_last_reg) begin
              boot_done_reg <= 1'b1;
              tbl_idx_reg   <= '0;
              reg_we_reg    <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              reg_addr_reg  <= tbl_addr;
              reg_wdata_reg <= tbl_data;
              reg_we_reg    <= 1'b1;
              lat_cnt_reg   <= '0;
            end
          end
        end
`endif

        default: state_reg <= ST_BOOT;
      endcase
    end
  end

  assign tbl_idx       = tbl_idx_reg;
  assign boot_done     = boot_done_reg;
  assign host_ack      = host_ack_reg;
  assign host_rdata    = host_rdata_reg;
  assign bus.reg_addr  = reg_addr_reg;
  assign bus.reg_wdata = reg_wdata_reg;
  assign bus.reg_we    = reg_we_reg;
  assign bus.reg_re    = reg_re_reg;

`ifdef HWAG_CFG_VERIFY_EN
  assign boot_busy = (state_reg == ST_BOOT) || (state_reg == ST_VRD_WAIT);
  assign boot_err  = boot_err_reg;
`else
  assign boot_busy = (state_reg == ST_BOOT);
  assign boot_err  = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_cfg_sequencer.sv
// Self-checking bench for hwag_cfg_sequencer: boot replay, host write/read, boot restart, async reset.
`timescale 1ns/1ps
module tb_hwag_cfg_sequencer;
  localparam int AW = 8, DW = 16, BOOT_LEN = 12, IDX_W = 4, RD_LAT = 1;
`ifdef HWAG_CFG_VERIFY_EN
  localparam int   BOOT_CYC = BOOT_LEN * (2 + RD_LAT);
  localparam logic EXP_ERR  = 1'b1;
`else
  localparam int   BOOT_CYC = BOOT_LEN;
  localparam logic EXP_ERR  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [IDX_W-1:0] tbl_idx;
  logic [AW-1:0]    tbl_addr;
  logic [DW-1:0]    tbl_data;
  logic             boot_start = 1'b0;
  logic             boot_busy, boot_done, boot_err;
  logic             host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0]    host_addr = '0;
  logic [DW-1:0]    host_wdata = '0;
  logic             host_ack;
  logic [DW-1:0]    host_rdata;

  hwag_cfg_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  hwag_cfg_sequencer #(
    .AW(AW), .DW(DW), .BOOT_LEN(BOOT_LEN), .IDX_W(IDX_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .boot_start(boot_start), .boot_busy(boot_busy), .boot_done(boot_done), .boot_err(boot_err),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .bus(bus)
  );

  always #5 clk = ~clk;

  // boot table ROM
  logic [AW-1:0] rom_addr [16];
  logic [DW-1:0] rom_data [16];
  assign tbl_addr = rom_addr[tbl_idx];
  assign tbl_data = rom_data[tbl_idx];

  // register file model with one cycle read latency
  logic [DW-1:0] mem [256] = '{70: 16'd2, default: 16'd0};
  always @(posedge clk) begin
    if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
`ifdef HWAG_CFG_VERIFY_EN
    if (bus.reg_re) bus.reg_rdata <= (bus.reg_addr == rom_addr[6]) ? (mem[bus.reg_addr] ^ 16'h0001)
                                                                    : mem[bus.reg_addr];
`else
    if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
`endif
  end

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct packed { logic is_rd; logic [DW-1:0] d; } host_t;
  wr_t   exp_wr_q [$];
  host_t exp_host_q [$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_boot();
    for (int i = 0; i < BOOT_LEN; i++) exp_wr_q.push_back('{a: rom_addr[i], d: rom_data[i]});
  endtask

  task automatic scoreboard_monitor();
    wr_t   e;
    host_t h;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.reg_we) begin
          n_total++;
          if (exp_wr_q.size() == 0) begin
            $display("FAIL sb_write unexpected a=%0d d=%0h, expected no write", bus.reg_addr, bus.reg_wdata);
          end else begin
            e = exp_wr_q.pop_front();
            if (bus.reg_addr !== e.a || bus.reg_wdata !== e.d)
              $display("FAIL sb_write got a=%0d d=%0h exp a=%0d d=%0h", bus.reg_addr, bus.reg_wdata, e.a, e.d);
            else begin
              n_pass++;
              $display("write a=%0d d=%0h", bus.reg_addr, bus.reg_wdata);
            end
          end
        end
        if (host_ack) begin
          n_total++;
          if (exp_host_q.size() == 0) begin
            $display("FAIL sb_host_ack unexpected ack rdata=%0h, expected none", host_rdata);
          end else begin
            h = exp_host_q.pop_front();
            if (h.is_rd && host_rdata !== h.d)
              $display("FAIL sb_host_rdata got %0h exp %0h", host_rdata, h.d);
            else begin
              n_pass++;
              $display("host ack rd=%0b rdata=%0h", h.is_rd, host_rdata);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (boot_busy !== 1'b1) $display("FAIL rst_busy got %0b exp 1", boot_busy); else n_pass++;
    n_total++; if (tbl_idx !== '0) $display("FAIL rst_idx got %0d exp 0", tbl_idx); else n_pass++;
    n_total++; if (bus.reg_we !== 1'b0 || bus.reg_re !== 1'b0) $display("FAIL rst_strobes got we=%0b re=%0b exp 0", bus.reg_we, bus.reg_re); else n_pass++;
    n_total++; if (host_ack !== 1'b0 || boot_done !== 1'b0 || boot_err !== 1'b0) $display("FAIL rst_flags got ack=%0b done=%0b err=%0b exp 0", host_ack, boot_done, boot_err); else n_pass++;
    n_total++; if (bus.reg_addr !== '0 || host_rdata !== '0) $display("FAIL rst_data got addr=%0h rdata=%0h exp 0", bus.reg_addr, host_rdata); else n_pass++;
  endtask

  task automatic test_boot_with_held_write();
    int done_cyc = 0, ack_cyc = 0, ack_width = 0;
    logic we_at_ack = 1'b0, we_c1 = 1'b0;
    push_boot();
    exp_wr_q.push_back('{a: 8'd63, d: 16'h0007});
    exp_host_q.push_back('{is_rd: 1'b0, d: 16'h0});
    rst = 1'b1;
    for (int c = 1; c <= BOOT_CYC + 4; c++) begin
      tick();
      if (c == 1) we_c1 = bus.reg_we;
      if (c == 2) begin host_req = 1'b1; host_we = 1'b1; host_addr = 8'd63; host_wdata = 16'h0007; end
      if (boot_done && done_cyc == 0) done_cyc = c;
      if (host_ack) begin
        ack_width++;
        if (ack_cyc == 0) begin ack_cyc = c; we_at_ack = bus.reg_we; end
        host_req = 1'b0;
      end
    end
    n_total++; if (we_c1 !== 1'b1) $display("FAIL boot_first_we got %0b exp 1 at cycle 1", we_c1); else n_pass++;
    n_total++; if (done_cyc != BOOT_CYC) $display("FAIL boot_done_cycle got %0d exp %0d", done_cyc, BOOT_CYC); else n_pass++;
    n_total++; if (ack_cyc != BOOT_CYC + 1) $display("FAIL held_write_ack_cycle got %0d exp %0d", ack_cyc, BOOT_CYC + 1); else n_pass++;
    n_total++; if (we_at_ack !== 1'b1 || ack_width != 1) $display("FAIL held_write_ack got we=%0b width=%0d exp we=1 width=1", we_at_ack, ack_width); else n_pass++;
    n_total++; if (boot_busy !== 1'b0 || boot_err !== EXP_ERR) $display("FAIL boot_end_flags got busy=%0b err=%0b exp busy=0 err=%0b", boot_busy, boot_err, EXP_ERR); else n_pass++;
  endtask

  task automatic test_host_read();
    int re_cyc = 0, re_cnt = 0, ack_cyc = 0;
    logic [AW-1:0] re_addr = '0;
    exp_host_q.push_back('{is_rd: 1'b1, d: 16'd2});
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd70;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.reg_re) begin re_cnt++; if (re_cyc == 0) begin re_cyc = c; re_addr = bus.reg_addr; end end
      if (host_ack && ack_cyc == 0) begin ack_cyc = c; host_req = 1'b0; end
    end
    n_total++; if (re_cyc != 1 || re_cnt != 1 || re_addr !== 8'd70) $display("FAIL read_strobe got cyc=%0d cnt=%0d addr=%0d exp 1 1 70", re_cyc, re_cnt, re_addr); else n_pass++;
    n_total++; if (ack_cyc != re_cyc + 1 + RD_LAT) $display("FAIL read_ack_cycle got %0d exp %0d", ack_cyc, re_cyc + 1 + RD_LAT); else n_pass++;
    n_total++; if (host_rdata !== 16'd2) $display("FAIL read_rdata_held got %0h exp 2", host_rdata); else n_pass++;
  endtask

  task automatic test_boot_start_during_read();
    int ack_cyc = 0, busy_cyc = 0, done_cyc = 0;
    logic done_at_busy = 1'b1;
    push_boot();
    exp_host_q.push_back('{is_rd: 1'b1, d: 16'h0007});
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd63;
    for (int c = 1; c <= BOOT_CYC + 12; c++) begin
      tick();
      boot_start = (c == 1);
      if (host_ack && ack_cyc == 0) begin ack_cyc = c; host_req = 1'b0; end
      if (boot_busy && busy_cyc == 0) begin busy_cyc = c; done_at_busy = boot_done; end
      if (busy_cyc != 0 && boot_done && done_cyc == 0) done_cyc = c;
    end
    n_total++; if (ack_cyc != 3) $display("FAIL restart_read_ack got %0d exp 3", ack_cyc); else n_pass++;
    n_total++; if (busy_cyc != 5 || done_at_busy !== 1'b0) $display("FAIL restart_busy got cyc=%0d done=%0b exp 5 0", busy_cyc, done_at_busy); else n_pass++;
    n_total++; if (done_cyc != busy_cyc + BOOT_CYC) $display("FAIL restart_done_cycle got %0d exp %0d", done_cyc, busy_cyc + BOOT_CYC); else n_pass++;
  endtask

  task automatic test_async_reset();
    int hit = 0, done_cyc = 0, first_we = 0;
    push_boot();
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    for (int c = 0; c < 60 && hit == 0; c++) begin
      tick();
      if (tbl_idx == 4'd5) hit = 1;
    end
    n_total++; if (hit != 1) $display("FAIL async_reach_idx5 got %0d exp 1", hit); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if (bus.reg_we !== 1'b0 || tbl_idx !== '0 || boot_busy !== 1'b1) $display("FAIL async_reset got we=%0b idx=%0d busy=%0b exp 0 0 1", bus.reg_we, tbl_idx, boot_busy); else n_pass++;
    n_total++; if (bus.reg_addr !== '0 || bus.reg_wdata !== '0 || boot_done !== 1'b0) $display("FAIL async_reset_data got a=%0h d=%0h done=%0b exp 0", bus.reg_addr, bus.reg_wdata, boot_done); else n_pass++;
    exp_wr_q.delete();
    push_boot();
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= BOOT_CYC + 3; c++) begin
      tick();
      if (bus.reg_we && first_we == 0) first_we = c;
      if (boot_done && done_cyc == 0) done_cyc = c;
    end
    n_total++; if (first_we != 1 || done_cyc != BOOT_CYC) $display("FAIL async_reboot got first_we=%0d done=%0d exp 1 %0d", first_we, done_cyc, BOOT_CYC); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ack1 = 0, ack2 = 0, n_ack = 0;
    exp_wr_q.push_back('{a: 8'd90, d: 16'h1111});
    exp_wr_q.push_back('{a: 8'd91, d: 16'h2222});
    exp_host_q.push_back('{is_rd: 1'b0, d: 16'h0});
    exp_host_q.push_back('{is_rd: 1'b0, d: 16'h0});
    exp_host_q.push_back('{is_rd: 1'b1, d: 16'h2222});
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'd90; host_wdata = 16'h1111;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (host_ack) begin
        n_ack++;
        if (n_ack == 1) begin ack1 = c; host_addr = 8'd91; host_wdata = 16'h2222; end
        else if (n_ack == 2) begin ack2 = c; host_we = 1'b0; end
        else host_req = 1'b0;
      end
    end
    n_total++; if (ack1 != 1 || ack2 != 3) $display("FAIL b2b_ack_cycles got %0d %0d exp 1 3", ack1, ack2); else n_pass++;
    n_total++; if (n_ack != 3 || host_rdata !== 16'h2222) $display("FAIL b2b_readback got acks=%0d rdata=%0h exp 3 2222", n_ack, host_rdata); else n_pass++;
  endtask

  initial begin
    rom_addr = '{8'd1, 8'd4, 8'd7, 8'd10, 8'd13, 8'd16, 8'd19, 8'd22, 8'd25, 8'd28, 8'd31, 8'd34,
                 8'd0, 8'd0, 8'd0, 8'd0};
    rom_data = '{16'd128, 16'd0, 16'd65535, 16'd0, 16'd57, 16'd4, 16'd3839, 16'd250,
                 16'd1000, 16'h1234, 16'hA5A5, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0};
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_boot_with_held_write();
    test_host_read();
    test_boot_start_during_read();
    test_async_reset();
    test_back_to_back();
    repeat (2) tick();
    n_total++; if (exp_wr_q.size() != 0 || exp_host_q.size() != 0) $display("FAIL sb_drain got wr=%0d host=%0d exp 0 0", exp_wr_q.size(), exp_host_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200us");
    $fatal(1, "timeout");
  end

endmodule
